// File: rtl/bd_cpld_recv_mc.sv
// ---------------------------------------------------------------------------
// bd_cpld_recv_mc
//
// Receives buffer-descriptor (BD) completions from the PCIe RC stream for
// several DMA channels. It strips the completion descriptor, re-aligns the
// payload across beat boundaries, and forwards whole BD beats tagged with
// {channel, beat index}. Output tlast marks the final beat of a complete BD
// fetch, which may be split over several completion TLPs depending on the
// max payload size.
//
// Ports
//   user_clk                  : clock (only clock of the block)
//   user_reset_n              : asynchronous active-low reset
//   cpld_first_beat           : high on the first beat of each completion TLP
//   axis_rc_bd_cpld_tvalid    : input stream valid
//   axis_rc_bd_cpld_tlast     : input stream last beat of TLP
//   axis_rc_bd_cpld_tready    : input stream ready (output)
//   axis_rc_bd_cpld_tdata     : input stream data, DATA_W bits
//   cfg_max_payload_size      : 0=128B, 1=256B, 2 and above=512B
//   bd_size_beats             : BD fetch length in DATA_W beats (1..63)
//   m_from_pcie_bd_tvalid     : output stream valid
//   m_from_pcie_bd_tlast      : output stream last beat of BD fetch
//   m_from_pcie_bd_tready     : output stream ready (input)
//   m_from_pcie_bd_tdata      : re-aligned BD data, DATA_W bits
//   m_from_pcie_bd_tuser      : {channel, bd beat index}
//   cpld_err                  : one-cycle pulse on a bad completion
//   cpld_err_ch               : channel of the last bad completion
// ---------------------------------------------------------------------------
module bd_cpld_recv_mc #(
  parameter int DATA_W = 256,
  parameter int CH_NUM = 4,
  parameter int CH_W   = 2,
  parameter int HDR_W  = 96
) (
  input  logic                user_clk,
  input  logic                user_reset_n,
  input  logic                cpld_first_beat,
  input  logic                axis_rc_bd_cpld_tvalid,
  input  logic                axis_rc_bd_cpld_tlast,
  output logic                axis_rc_bd_cpld_tready,
  input  logic [DATA_W-1:0]   axis_rc_bd_cpld_tdata,
  input  logic [2:0]          cfg_max_payload_size,
  input  logic [5:0]          bd_size_beats,
  output logic                m_from_pcie_bd_tvalid,
  output logic                m_from_pcie_bd_tlast,
  input  logic                m_from_pcie_bd_tready,
  output logic [DATA_W-1:0]   m_from_pcie_bd_tdata,
  output logic [CH_W+3:0]     m_from_pcie_bd_tuser,
  output logic                cpld_err,
  output logic [CH_W-1:0]     cpld_err_ch
);

  localparam int CARRY_W = DATA_W - HDR_W;
  // log2 of the beats in a 128-byte payload: 2 for 256-bit, 1 for 512-bit.
  localparam int MPS_BASE = 7 - $clog2(DATA_W / 8);

  typedef enum logic [0:0] {
    ST_WAIT_FIRST = 1'b0,
    ST_IN_TLP     = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [CH_W-1:0]    ch_reg;
  logic [3:0]         idx_reg;
  logic               bad_reg;
  logic [CARRY_W-1:0] carry_reg;
  logic [5:0]         cnt_reg  [CH_NUM];
  logic [5:0]         cnt_next [CH_NUM];

  logic               m_tvalid_reg;
  logic               m_tlast_reg;
  logic [DATA_W-1:0]  m_tdata_reg;
  logic [CH_W+3:0]    m_tuser_reg;
  logic               cpld_err_reg;
  logic [CH_W-1:0]    cpld_err_ch_reg;

  // -------------------------------------------------------------------------
  // Completions per BD fetch. Payload sizes are powers of two in beats, so
  // ceil(bd/mps)-1 is simply (bd-1) >> log2(mps); this never overflows 6 bits.
  // -------------------------------------------------------------------------
  logic [1:0] mps_sel;
  logic [2:0] mps_log2;
  logic [5:0] bd_minus1;
  logic [5:0] cpld_num;

  assign mps_sel   = (cfg_max_payload_size >= 3'd2) ? 2'd2 : cfg_max_payload_size[1:0];
  assign mps_log2  = {1'b0, mps_sel} + 3'(MPS_BASE);
  assign bd_minus1 = bd_size_beats - 6'd1;
  assign cpld_num  = bd_minus1 >> mps_log2;

  // -------------------------------------------------------------------------
  // Input handshake and per-beat decode
  // -------------------------------------------------------------------------
  logic            in_xfer;
  logic            first_xfer;
  logic [CH_W-1:0] hdr_ch;
  logic            hdr_bad;
  logic [CH_W-1:0] cur_ch;
  logic            beat_live;
  logic            count_xfer;
  logic            data_xfer;
  logic            cnt_hit;

  assign axis_rc_bd_cpld_tready = ~m_tvalid_reg | m_from_pcie_bd_tready;
  assign in_xfer    = axis_rc_bd_cpld_tvalid & axis_rc_bd_cpld_tready;
  assign first_xfer = in_xfer & cpld_first_beat;

  assign hdr_ch  = axis_rc_bd_cpld_tdata[64 +: CH_W];
  assign hdr_bad = (axis_rc_bd_cpld_tdata[45:43] != 3'd0) | axis_rc_bd_cpld_tdata[46];

  // A header-only TLP must be counted against the channel in its own header,
  // so the channel comes straight from the beat on first beats.
  assign cur_ch = cpld_first_beat ? hdr_ch : ch_reg;

  // Beats arriving before any first beat (e.g. the tail of a TLP cut by
  // reset) belong to no known completion and are silently dropped.
  assign beat_live  = cpld_first_beat | (state_reg == ST_IN_TLP);
  assign count_xfer = in_xfer & axis_rc_bd_cpld_tlast & beat_live;
  assign data_xfer  = in_xfer & ~cpld_first_beat & (state_reg == ST_IN_TLP) & ~bad_reg;
  assign cnt_hit    = (cnt_reg[cur_ch] == cpld_num);

  // -------------------------------------------------------------------------
  // Per-channel completion counters
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_cnt
      logic sel;
      assign sel = count_xfer & (cur_ch == CH_W'(gi));
      assign cnt_next[gi] = !sel                    ? cnt_reg[gi] :
                            (cnt_reg[gi] == cpld_num) ? 6'd0      :
                                                        cnt_reg[gi] + 6'd1;
    end
  endgenerate

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_reg[i] <= 6'd0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // TLP tracking FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_reg <= ST_WAIT_FIRST;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (first_xfer) begin
      // A first beat always (re)starts a TLP, even mid-TLP.
      state_next = axis_rc_bd_cpld_tlast ? ST_WAIT_FIRST : ST_IN_TLP;
    end else if (in_xfer && axis_rc_bd_cpld_tlast) begin
      state_next = ST_WAIT_FIRST;
    end
  end

  // -------------------------------------------------------------------------
  // Header latch, carry register and error reporting
  // -------------------------------------------------------------------------
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      ch_reg          <= '0;
      idx_reg         <= 4'd0;
      bad_reg         <= 1'b0;
      carry_reg       <= '0;
      cpld_err_reg    <= 1'b0;
      cpld_err_ch_reg <= '0;
    end else begin
      cpld_err_reg <= first_xfer & hdr_bad;
      if (in_xfer) begin
        carry_reg <= axis_rc_bd_cpld_tdata[DATA_W-1:HDR_W];
      end
      if (first_xfer) begin
        ch_reg  <= hdr_ch;
        idx_reg <= axis_rc_bd_cpld_tdata[8:5];
        bad_reg <= hdr_bad;
        if (hdr_bad) begin
          cpld_err_ch_reg <= hdr_ch;
        end
      end else if (data_xfer) begin
        idx_reg <= idx_reg + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register stage. Data/user/last only change on a load, and a load
  // can only happen when the stage is empty or being drained this cycle, so
  // the payload holds while stalled.
  // -------------------------------------------------------------------------
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
      m_tdata_reg  <= '0;
      m_tuser_reg  <= '0;
    end else if (data_xfer) begin
      m_tvalid_reg <= 1'b1;
      // Previous beat's payload tail sits below this beat's low HDR_W bits.
      m_tdata_reg  <= {axis_rc_bd_cpld_tdata[HDR_W-1:0], carry_reg};
      m_tuser_reg  <= {ch_reg, idx_reg};
      m_tlast_reg  <= axis_rc_bd_cpld_tlast & cnt_hit;
    end else if (m_from_pcie_bd_tready) begin
      m_tvalid_reg <= 1'b0;
    end
  end

  assign m_from_pcie_bd_tvalid = m_tvalid_reg;
  assign m_from_pcie_bd_tlast  = m_tlast_reg;
  assign m_from_pcie_bd_tdata  = m_tdata_reg;
  assign m_from_pcie_bd_tuser  = m_tuser_reg;
  assign cpld_err              = cpld_err_reg;
  assign cpld_err_ch           = cpld_err_ch_reg;

endmodule
